ps2_init_seq: RTL

PS2_INIT_SEQ -- requirements
Module: ps2_init_seq

---
 rtl/ps2_init_seq.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_init_seq
//  Description : PS/2 mouse initialisation sequencer. Sends the reset
//                command, waits for ACK / BAT / device ID, optionally
//                programs the sample rate, then enables stream mode.
//                Handles resend (0xFE), restart on bad responses and
//                response timeouts, bounded by a retry limit.
//                Optional feature macro: PS2_SAMPLE_RATE_EN
//                  defined   -> sequence FF, F3, SAMPLE_RATE, F4
//                  undefined -> sequence FF, F4 (no rate logic)
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_init_seq #(
    parameter int         TIMEOUT_CYC = 37500000,
    parameter int         MAX_RETRY   = 3,
    parameter logic [7:0] SAMPLE_RATE = 8'd100
) (
    input  logic       iCLK_50,
    input  logic       iRST_n,
    input  logic       iSTART,
    output logic [7:0] oTX_DATA,
    output logic       oTX_REQ,
    input  logic       iTX_DONE,
    input  logic       iTX_ERR,
    input  logic [7:0] iRX_DATA,
    input  logic       iRX_VALID,
    output logic       oREADY,
    output logic       oERROR,
    output logic [3:0] oSTATE
);

    // ------------------------------------------------------------------
    // State encoding (also exported on oSTATE for debug)
    // ------------------------------------------------------------------
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_SEND     = 4'd1;
    localparam logic [3:0] ST_WAIT_ACK = 4'd2;
    localparam logic [3:0] ST_WAIT_BAT = 4'd3;
    localparam logic [3:0] ST_WAIT_ID  = 4'd4;
    localparam logic [3:0] ST_NEXT     = 4'd5;
    localparam logic [3:0] ST_READY    = 4'd6;
    localparam logic [3:0] ST_ERROR    = 4'd7;

    // PS/2 protocol bytes
    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_STREAM = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;

`ifdef PS2_SAMPLE_RATE_EN
    localparam logic [7:0] CMD_RATE   = 8'hF3;
    localparam logic [1:0] LAST_IDX   = 2'd3;
`else
    localparam logic [1:0] LAST_IDX   = 2'd1;
`endif

    // Timeout fires on the cycle the counter reaches TIMEOUT_CYC-1, so a
    // state is left after exactly TIMEOUT_CYC cycles of silence.
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

    // Command byte selected by the sequence index
    function automatic logic [7:0] cmd_byte(input logic [1:0] idx);
        logic [7:0] b;
`ifdef PS2_SAMPLE_RATE_EN
        case (idx)
            2'd0:    b = CMD_RESET;
            2'd1:    b = CMD_RATE;
            2'd2:    b = SAMPLE_RATE;
            default: b = CMD_STREAM;
        endcase
`else
        b = (idx == 2'd0) ? CMD_RESET : CMD_STREAM;
`endif
        return b;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [3:0]  state_q,   state_d;
    logic [1:0]  idx_q,     idx_d;
    logic [3:0]  retry_q,   retry_d;
    logic [31:0] tmo_q,     tmo_d;
    logic        tx_req_q,  tx_req_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        ready_q,   ready_d;
    logic        error_q,   error_d;
    logic        start_q;

    logic w_start_edge;
    logic w_counting;
    logic w_tmo_hit;
    logic w_resend;
    logic w_restart;
    logic w_reenter;

    assign w_start_edge = iSTART & ~start_q;
    assign w_counting   = (state_q == ST_SEND)     || (state_q == ST_WAIT_ACK) ||
                          (state_q == ST_WAIT_BAT) || (state_q == ST_WAIT_ID);
    assign w_tmo_hit    = w_counting && (tmo_q == TMO_LAST);

    // Next-state logic: start edge first, then bus/RX events, then timeout
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        tmo_d     = tmo_q;
        tx_req_d  = 1'b0;
        tx_data_d = tx_data_q;
        ready_d   = ready_q;
        error_d   = error_q;
        w_resend  = 1'b0;
        w_restart = 1'b0;
        w_reenter = 1'b0;

        if (w_start_edge) begin
            // Abort whatever is in progress; request rises one cycle later
            state_d   = ST_SEND;
            idx_d     = 2'd0;
            retry_d   = 4'd0;
            ready_d   = 1'b0;
            error_d   = 1'b0;
            w_reenter = 1'b1;
        end else begin
            case (state_q)
                ST_SEND: begin
                    if (iTX_DONE)       state_d   = ST_WAIT_ACK;
                    else if (iTX_ERR)   w_resend  = 1'b1;
                    else if (w_tmo_hit) w_restart = 1'b1;
                    else                tx_req_d  = 1'b1;
                end
                ST_WAIT_ACK: begin
                    if (iRX_VALID) begin
                        if (iRX_DATA == RSP_ACK)
                            state_d = (idx_q == 2'd0) ? ST_WAIT_BAT : ST_NEXT;
                        else if (iRX_DATA == RSP_RESEND)
                            w_resend = 1'b1;
                        else
                            w_restart = 1'b1;
                    end else if (w_tmo_hit) begin
                        w_restart = 1'b1;
                    end
                end
                ST_WAIT_BAT: begin
                    if (iRX_VALID) begin
                        if (iRX_DATA == RSP_BAT_OK) state_d   = ST_WAIT_ID;
                        else                        w_restart = 1'b1;
                    end else if (w_tmo_hit) begin
                        w_restart = 1'b1;
                    end
                end
                ST_WAIT_ID: begin
                    // Device ID value is not used
                    if (iRX_VALID)      state_d   = ST_NEXT;
                    else if (w_tmo_hit) w_restart = 1'b1;
                end
                ST_NEXT: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_READY;
                        retry_d = 4'd0;
                        ready_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_SEND;
                    end
                end
                default: ; // IDLE, READY, ERROR wait for a start edge
            endcase

            // Shared resend/restart path, bounded by the retry limit
            if (w_resend || w_restart) begin
                if (retry_q >= RETRY_MAX) begin
                    state_d = ST_ERROR;
                    error_d = 1'b1;
                end else begin
                    retry_d   = retry_q + 4'd1;
                    state_d   = ST_SEND;
                    w_reenter = 1'b1;
                    if (w_restart) idx_d = 2'd0;
                end
            end
        end

        // Command byte is loaded on the way into SEND and held there
        if (state_d == ST_SEND) tx_data_d = cmd_byte(idx_d);

        // Timeout counter restarts on every state entry, including re-entry
        if (w_reenter || (state_d != state_q)) tmo_d = 32'd0;
        else if (w_counting)                   tmo_d = tmo_q + 32'd1;
    end

    // State and output registers; reset clears everything immediately
    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            retry_q   <= 4'd0;
            tmo_q     <= 32'd0;
            tx_req_q  <= 1'b0;
            tx_data_q <= 8'h00;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            tmo_q     <= tmo_d;
            tx_req_q  <= tx_req_d;
            tx_data_q <= tx_data_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            start_q   <= iSTART;
        end
    end

    assign oTX_DATA = tx_data_q;
    assign oTX_REQ  = tx_req_q;
    assign oREADY   = ready_q;
    assign oERROR   = error_q;
    assign oSTATE   = state_q;

endmodule
`default_nettype wire
